// File: rtl/pos_logic_pipe.sv
// Pipelined bitwise logic unit: eight ops on a/b, STAGES-deep valid/ready pipe with result flags.
// Optional macro LOGIC_PIPE_CNT_EN adds a saturating completed-op counter on op_count.
module pos_logic_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [15:0]      op_count
);

    generate
        if (STAGES < 1 || STAGES > 4 || WIDTH < 2) begin : g_bad_cfg
            $error("pos_logic_pipe: STAGES must be 1..4 and WIDTH >= 2");
        end
    endgenerate

    // Handshake: a transfer happens on a rising edge where valid && ready; valid never
    // waits on ready, and a held valid keeps its data stable until the transfer.

    logic [WIDTH-1:0] res;
    logic [2:0]       res_flags;   // {parity, ones, zero}

    always_comb begin
        res = '0;
        case (op)
            3'b000:  res = a & b;
            3'b001:  res = a | b;
            3'b010:  res = a ^ b;
            3'b011:  res = ~(a & b);
            3'b100:  res = ~(a | b);
            3'b101:  res = ~(a ^ b);
            3'b110:  res = a & ~b;
            default: res = a;
        endcase
    end

    assign res_flags = {^res, &res, ~|res};

    logic [STAGES-1:0] stg_valid;
    logic [WIDTH-1:0]  stg_data  [STAGES];
    logic [2:0]        stg_flags [STAGES];

    // What each stage would capture: stage 0 takes the operands, stage k the one before it.
    logic [STAGES-1:0] feed_valid;
    logic [WIDTH-1:0]  feed_data  [STAGES];
    logic [2:0]        feed_flags [STAGES];

    always_comb begin
        feed_valid    = '0;
        feed_valid[0] = in_valid;
        feed_data[0]  = res;
        feed_flags[0] = res_flags;
        for (int k = 1; k < STAGES; k++) begin
            feed_valid[k] = stg_valid[k-1];
            feed_data[k]  = stg_data[k-1];
            feed_flags[k] = stg_flags[k-1];
        end
    end

    // A stage advances if it is empty, the output is taken, or any later stage has a hole.
    logic [STAGES-1:0] adv;
    logic              go;

    always_comb begin
        adv = '0;
        go  = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            go     = go || !stg_valid[k];
            adv[k] = go;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stg_data[k]  <= '0;
                stg_flags[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    stg_valid[k] <= feed_valid[k];
                    if (feed_valid[k]) begin
                        stg_data[k]  <= feed_data[k];
                        stg_flags[k] <= feed_flags[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = stg_valid[STAGES-1];
    assign out       = stg_data[STAGES-1];
    assign parity    = stg_flags[STAGES-1][2];
    assign ones      = stg_flags[STAGES-1][1];
    assign zero      = stg_flags[STAGES-1][0];

`ifdef LOGIC_PIPE_CNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (out_valid && out_ready && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign op_count = cnt;
`else
    assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pos_logic_pipe.sv
// Randomised bench for pos_logic_pipe: truth-table reference model, expected-result queue,
// plus STAGES=1 and STAGES=4 instances checked for exact latency while streaming.
`timescale 1ns/1ps
module tb_pos_logic_pipe;

    localparam int W = 16;

`ifdef LOGIC_PIPE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid, out_ready;
    logic [2:0]   op;
    logic [W-1:0] a, b;

    logic         in_ready, out_valid, zero, ones, parity;
    logic [W-1:0] out;
    logic [15:0]  op_count;

    logic         in_ready_s1, out_valid_s1, zero_s1, ones_s1, parity_s1;
    logic [W-1:0] out_s1;
    logic [15:0]  op_count_s1;
    logic         in_ready_s4, out_valid_s4, zero_s4, ones_s4, parity_s4;
    logic [W-1:0] out_s4;
    logic [15:0]  op_count_s4;

    pos_logic_pipe #(.WIDTH(W), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .zero(zero), .ones(ones), .parity(parity), .op_count(op_count));

    pos_logic_pipe #(.WIDTH(W), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s1), .op(op),
        .a(a), .b(b), .out_valid(out_valid_s1), .out_ready(out_ready), .out(out_s1),
        .zero(zero_s1), .ones(ones_s1), .parity(parity_s1), .op_count(op_count_s1));

    pos_logic_pipe #(.WIDTH(W), .STAGES(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s4), .op(op),
        .a(a), .b(b), .out_valid(out_valid_s4), .out_ready(out_ready), .out(out_s4),
        .zero(zero_s4), .ones(ones_s4), .parity(parity_s4), .op_count(op_count_s4));

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each op is a 2-input truth table indexed by {a_bit, b_bit}.
    logic [3:0] tt [8];

    function automatic logic [W+2:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        logic [W-1:0] r;
        logic [3:0]   t;
        t = tt[o];
        for (int i = 0; i < W; i++) r[i] = t[{x[i], y[i]}];
        return {r, (r == 0), (r == {W{1'b1}}), 1'($countones(r) % 2)};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W+2:0] exp_q[$];
    int           stamp_q[$];
    logic [W+2:0] got_q[$];
    int           cyc = 0;
    int           cnt_model = 0;
    bit           lat_chk = 0;
    bit           stream_on = 0;
    bit           last_in_fire = 0;
    bit           held_valid = 0;
    logic [W+2:0] held_obs;
    logic         hv [8];
    logic [W-1:0] hd [8];

    // One clock cycle: called just after a negedge with inputs already set.
    task automatic cycle();
        logic [W+2:0] obs;
        logic [W+2:0] e;
        int           sat;
        #1;
        cyc++;
        obs = {out, zero, ones, parity};
        sat = (cnt_model > 65535) ? 65535 : cnt_model;
        check("op_count", {16'h0, op_count}, CNT_ON ? sat : 0);

        if (held_valid) begin
            check("hold_valid", {31'h0, out_valid}, 1);
            check("hold_out", {13'h0, obs}, {13'h0, held_obs});
        end
        if (out_valid) begin
            if (exp_q.size() == 0) check("spurious_out", {31'h0, out_valid}, 0);
            else check("out_data", {13'h0, obs}, {13'h0, exp_q[0]});
        end
        held_valid = out_valid && !out_ready;
        held_obs   = obs;

        if (out_valid && out_ready && exp_q.size() > 0) begin
            if (lat_chk) check("latency", cyc - stamp_q[0], 2);
            got_q.push_back(obs);
            void'(exp_q.pop_front());
            void'(stamp_q.pop_front());
            cnt_model++;
        end

        e = model(op, a, b);
        last_in_fire = in_valid && in_ready;
        if (last_in_fire) begin
            exp_q.push_back(e);
            stamp_q.push_back(cyc);
        end

        if (stream_on) begin
            check("s1_ready", {31'h0, in_ready_s1}, 1);
            check("s4_ready", {31'h0, in_ready_s4}, 1);
            check("s1_valid", {31'h0, out_valid_s1}, {31'h0, hv[(cyc - 1) % 8]});
            check("s4_valid", {31'h0, out_valid_s4}, {31'h0, hv[(cyc - 4) % 8]});
            if (hv[(cyc - 1) % 8]) check("s1_out", {16'h0, out_s1}, {16'h0, hd[(cyc - 1) % 8]});
            if (hv[(cyc - 4) % 8]) check("s4_out", {16'h0, out_s4}, {16'h0, hd[(cyc - 4) % 8]});
        end
        hv[cyc % 8] = in_valid;
        hd[cyc % 8] = e[W+2:3];
        @(negedge clk);
    endtask

    // ---------------- drivers ----------------
    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        op = o; a = x; b = y; in_valid = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_in_fire && n < 50);
        if (!last_in_fire) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            cycle();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] tab [8];
    logic [W-1:0] bp_a [4];
    logic [W-1:0] bp_b [4];
    logic [2:0]   bp_op [4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int n;
        tt  = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0100, 4'b1100};
        tab = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, 16'h000F, 16'hF00F, 16'h00F0, 16'hF0F0};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'h0, out_valid}, 0);
        check("rst_out", {16'h0, out}, 0);
        check("rst_flags", {29'h0, zero, ones, parity}, 0);
        check("rst_count", {16'h0, op_count}, 0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", {31'h0, in_ready}, 1);
        @(negedge clk);

        // all eight ops on the reference operand pair
        out_ready = 1'b1;
        lat_chk   = 1;
        got_q.delete();
        for (int i = 0; i < 8; i++) send(3'(i), 16'hF0F0, 16'hFF00);
        drain();
        check("ops_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            check($sformatf("op_tab%0d", i), {16'h0, got_q[i][W+2:3]}, {16'h0, tab[i]});

        // flag corners
        got_q.delete();
        send(3'b000, 16'hAAAA, 16'h5555);
        send(3'b001, 16'hAAAA, 16'h5555);
        drain();
        check("flag_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("and_out", {16'h0, got_q[0][W+2:3]}, 0);
            check("and_zero", {31'h0, got_q[0][2]}, 1);
            check("and_parity", {31'h0, got_q[0][0]}, 0);
            check("or_out", {16'h0, got_q[1][W+2:3]}, 32'hFFFF);
            check("or_ones", {31'h0, got_q[1][1]}, 1);
            check("or_zero", {31'h0, got_q[1][2]}, 0);
        end

        // backpressure: four back-to-back ops against a stalled output
        lat_chk = 0;
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = W'($urandom); bp_b[i] = W'($urandom); bp_op[i] = 3'($urandom_range(0, 7));
        end
        idx = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op = bp_op[idx % 4]; a = bp_a[idx % 4]; b = bp_b[idx % 4];
            cycle();
            if (last_in_fire) idx++;
        end
        check("bp_accepts", idx, 2);
        #1 check("bp_in_ready", {31'h0, in_ready}, 0);
        out_ready = 1'b1;
        n = 0;
        while (idx < 4 && n < 20) begin
            op = bp_op[idx]; a = bp_a[idx]; b = bp_b[idx];
            cycle();
            if (last_in_fire) idx++;
            n++;
        end
        drain();
        check("bp_results", got_q.size(), 4);

        // random valid / ready mix
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
            if ((i % 50) == 7) begin a = W'($urandom); b = ~a; op = 3'($urandom_range(0, 1)); end
            cycle();
        end
        drain();
        idle(8);

        // full-rate streaming on all three depths
        lat_chk   = 1;
        stream_on = 1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            op = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
            cycle();
        end
        idle(6);
        stream_on = 0;
        check("stream_empty", exp_q.size(), 0);

        // reset in the middle of a stream
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
            cycle();
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_valid", {31'h0, out_valid}, 0);
        check("mid_rst_out", {16'h0, out}, 0);
        check("mid_rst_flags", {29'h0, zero, ones, parity}, 0);
        check("mid_rst_count", {16'h0, op_count}, 0);
        exp_q.delete(); stamp_q.delete(); cnt_model = 0; held_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_in_ready", {31'h0, in_ready}, 1);
        @(negedge clk);
        send(3'b010, 16'h1234, 16'h00FF);
        drain();

`ifdef LOGIC_PIPE_CNT_EN
        lat_chk = 0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            op = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
            cycle();
        end
        drain();
        check("cnt_saturated", {16'h0, op_count}, 32'hFFFF);
`else
        check("cnt_off", {16'h0, op_count}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
